// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: streaming Karatsuba multiplier, signed/unsigned per transaction, ready/valid with tag sideband.
// Sign-magnitude front end, three pipelined sub-products, recombination and sign restore at the output register.
module karatsuba_mult_pipe #(
    parameter int WIDTH      = 24,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               signed_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic [TAG_W-1:0]   tag_o
);
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;
    localparam int SW   = HI_W + 1;
    localparam int HW   = 2 * HI_W;
    localparam int LW   = 2 * LO_W;
    localparam int MW   = 2 * HI_W + 2;
    localparam int PW   = 2 * WIDTH;

    logic             en;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [HI_W-1:0]  ah, bh;
    logic [LO_W-1:0]  al, bl;
    logic [SW-1:0]    sum_a, sum_b;
    logic             s1_neg, s1_v;
    logic [TAG_W-1:0] s1_tag;
    logic [HW-1:0]    ph     [MUL_STAGES];
    logic [LW-1:0]    pl     [MUL_STAGES];
    logic [MW-1:0]    pm     [MUL_STAGES];
    logic [TAG_W-1:0] mp_tag [MUL_STAGES];
    logic [MUL_STAGES-1:0] mp_neg, mp_v;
    logic [HW-1:0]    m_ph;
    logic [LW-1:0]    m_pl;
    logic [MW-1:0]    mid;
    logic             m_neg, m_v;
    logic [TAG_W-1:0] m_tag;
    logic [PW-1:0]    r;

    // Global stall: the whole pipe freezes while a result waits downstream.
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;
    assign sa      = signed_i & multiplicand_i[WIDTH-1];
    assign sb      = signed_i & multiplier_i[WIDTH-1];
    assign mag_a   = sa ? -multiplicand_i : multiplicand_i;
    assign mag_b   = sb ? -multiplier_i : multiplier_i;
    // Ph and Pl occupy disjoint bit ranges, so concatenation is the shifted sum.
    assign r       = {m_ph, m_pl} + (PW'(mid) << LO_W);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ah        <= '0;
            al        <= '0;
            bh        <= '0;
            bl        <= '0;
            sum_a     <= '0;
            sum_b     <= '0;
            s1_neg    <= 1'b0;
            s1_v      <= 1'b0;
            s1_tag    <= '0;
            for (int k = 0; k < MUL_STAGES; k++) begin
                ph[k]     <= '0;
                pl[k]     <= '0;
                pm[k]     <= '0;
                mp_tag[k] <= '0;
            end
            mp_neg    <= '0;
            mp_v      <= '0;
            m_ph      <= '0;
            m_pl      <= '0;
            mid       <= '0;
            m_neg     <= 1'b0;
            m_v       <= 1'b0;
            m_tag     <= '0;
            valid_o   <= 1'b0;
            product_o <= '0;
            tag_o     <= '0;
        end else if (en) begin
            ah        <= mag_a[WIDTH-1:LO_W];
            al        <= mag_a[LO_W-1:0];
            bh        <= mag_b[WIDTH-1:LO_W];
            bl        <= mag_b[LO_W-1:0];
            sum_a     <= SW'(mag_a[WIDTH-1:LO_W]) + SW'(mag_a[LO_W-1:0]);
            sum_b     <= SW'(mag_b[WIDTH-1:LO_W]) + SW'(mag_b[LO_W-1:0]);
            s1_neg    <= sa ^ sb;
            s1_v      <= valid_i;
            s1_tag    <= tag_i;
            ph[0]     <= HW'(ah) * HW'(bh);
            pl[0]     <= LW'(al) * LW'(bl);
            pm[0]     <= MW'(sum_a) * MW'(sum_b);
            mp_neg[0] <= s1_neg;
            mp_v[0]   <= s1_v;
            mp_tag[0] <= s1_tag;
            for (int k = 1; k < MUL_STAGES; k++) begin
                ph[k]     <= ph[k-1];
                pl[k]     <= pl[k-1];
                pm[k]     <= pm[k-1];
                mp_neg[k] <= mp_neg[k-1];
                mp_v[k]   <= mp_v[k-1];
                mp_tag[k] <= mp_tag[k-1];
            end
            m_ph      <= ph[MUL_STAGES-1];
            m_pl      <= pl[MUL_STAGES-1];
            mid       <= pm[MUL_STAGES-1] - MW'(ph[MUL_STAGES-1]) - MW'(pl[MUL_STAGES-1]);
            m_neg     <= mp_neg[MUL_STAGES-1];
            m_v       <= mp_v[MUL_STAGES-1];
            m_tag     <= mp_tag[MUL_STAGES-1];
            valid_o   <= m_v;
            product_o <= m_neg ? -r : r;
            tag_o     <= m_tag;
        end
    end
endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// tb_karatsuba_mult_pipe: random and directed checks of karatsuba_mult_pipe against an arithmetic reference.
module tb_karatsuba_mult_pipe;
    localparam int L  = 5;
    localparam int L7 = 4;
    localparam int N7 = 2 * 128 * 128;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i, ready_o, signed_i, valid_o, ready_i;
    logic [3:0]  tag_i, tag_o;
    logic [23:0] a, b;
    logic [47:0] product_o;
    logic        v7, rd7, s7, vo7, r7;
    logic [3:0]  t7, to7;
    logic [6:0]  a7, b7;
    logic [13:0] p7;
    int          checks = 0;
    int          errors = 0;
    logic [51:0] q24 [$];
    logic [17:0] q7 [$];

    always #5 clk = ~clk;

    karatsuba_mult_pipe #(.WIDTH(24), .MUL_STAGES(2), .TAG_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o), .signed_i(signed_i),
        .tag_i(tag_i), .multiplicand_i(a), .multiplier_i(b), .valid_o(valid_o), .ready_i(ready_i),
        .product_o(product_o), .tag_o(tag_o)
    );

    karatsuba_mult_pipe #(.WIDTH(7), .MUL_STAGES(1), .TAG_W(4)) dut7 (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(v7), .ready_o(rd7), .signed_i(s7),
        .tag_i(t7), .multiplicand_i(a7), .multiplier_i(b7), .valid_o(vo7), .ready_i(r7),
        .product_o(p7), .tag_o(to7)
    );

    function automatic logic [47:0] model24(input logic s, input logic [23:0] x, input logic [23:0] y);
        longint p;
        p = s ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
        return p[47:0];
    endfunction

    function automatic logic [13:0] model7(input logic s, input logic [6:0] x, input logic [6:0] y);
        int p;
        p = s ? int'($signed(x)) * int'($signed(y)) : int'(x) * int'(y);
        return p[13:0];
    endfunction

    function automatic logic [23:0] rnd24();
        case ($urandom_range(0, 7))
            0: return 24'h800000;
            1: return 24'hFFFFFF;
            2: return 24'h000000;
            3: return 24'h7FFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic randomize_in();
        signed_i = 1'($urandom_range(0, 1));
        a        = rnd24();
        b        = rnd24();
        tag_i    = 4'($urandom);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (valid_o !== 1'b0 || product_o !== 48'h0 || tag_o !== 4'h0 || vo7 !== 1'b0 || p7 !== 14'h0)
            begin errors++; $display("FAIL reset_state: valid_o=%b product_o=%h tag_o=%h vo7=%b, required 0", valid_o, product_o, tag_o, vo7); end
        @(posedge clk);
        @(posedge clk);
        #3 rstn_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || rd7 !== 1'b1 || valid_o !== 1'b0)
            begin errors++; $display("FAIL reset_release: ready_o=%b rd7=%b valid_o=%b, required 1 1 0", ready_o, rd7, valid_o); end
    endtask

    task automatic test_corners();
        logic        cs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [23:0] ca [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'h800000, 24'h800000, 24'h000000, 24'h7FFFFF};
        logic [23:0] cb [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h800000, 24'hFFFFFF, 24'h800000};
        logic [47:0] ce [6] = '{48'hFFFFFE000001, 48'h000000000001, 48'hFFFFFF800000,
                                48'h400000000000, 48'h000000000000, 48'hC00000800000};
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_i  = 1'b1;
            signed_i = cs[i];
            a        = ca[i];
            b        = cb[i];
            tag_i    = 4'(i + 3);
            @(posedge clk);
            #1 valid_i = 1'b0;
            for (int j = 1; j <= L; j++) begin
                @(negedge clk);
                checks++;
                if (valid_o !== (j == L))
                    begin errors++; $display("FAIL corner%0d_latency: cycle %0d valid_o=%b, required %b", i, j, valid_o, j == L); end
                if (j == L) begin
                    checks++;
                    if (product_o !== ce[i] || tag_o !== 4'(i + 3))
                        begin errors++; $display("FAIL corner%0d_value: product_o=%h tag_o=%h, required %h %h", i, product_o, tag_o, ce[i], 4'(i + 3)); end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0, first = -1;
        logic [51:0] e;
        q24.delete();
        ready_i = 1'b1;
        while (got < 100 && cyc < 1000) begin
            valid_i = sent < 100;
            randomize_in();
            @(negedge clk);
            if (valid_i && ready_o) begin q24.push_back({tag_i, model24(signed_i, a, b)}); sent++; end
            if (valid_o && ready_i) begin
                if (first < 0) first = cyc;
                checks++;
                if (q24.size() == 0) begin errors++; $display("FAIL stream_extra: unexpected result %h", product_o); end
                else begin
                    e = q24.pop_front();
                    if ({tag_o, product_o} !== e)
                        begin errors++; $display("FAIL stream_value: tag/product=%h, required %h", {tag_o, product_o}, e); end
                end
                got++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        valid_i = 1'b0;
        checks++;
        if (got != 100 || first != L || cyc != 100 + L)
            begin errors++; $display("FAIL stream_throughput: got=%0d first=%0d cycles=%0d, required 100 %0d %0d", got, first, cyc, L, 100 + L); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0;
        logic held = 1'b0;
        logic [47:0] hp = '0;
        logic [3:0] ht = '0;
        logic [51:0] e;
        q24.delete();
        while (got < 1000 && cyc < 20000) begin
            valid_i = (sent < 1000) && ($urandom_range(0, 3) != 0);
            randomize_in();
            ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held) begin
                checks++;
                if (valid_o !== 1'b1 || product_o !== hp || tag_o !== ht || ready_o !== ready_i)
                    begin errors++; $display("FAIL stall_hold: valid_o=%b product_o=%h tag_o=%h, required 1 %h %h", valid_o, product_o, tag_o, hp, ht); end
            end
            held = valid_o && !ready_i;
            hp   = product_o;
            ht   = tag_o;
            if (valid_i && ready_o) begin q24.push_back({tag_i, model24(signed_i, a, b)}); sent++; end
            if (valid_o && ready_i) begin
                checks++;
                if (q24.size() == 0) begin errors++; $display("FAIL bp_extra: unexpected result %h", product_o); end
                else begin
                    e = q24.pop_front();
                    if ({tag_o, product_o} !== e)
                        begin errors++; $display("FAIL bp_value: tag/product=%h, required %h", {tag_o, product_o}, e); end
                end
                got++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (got != 1000 || q24.size() != 0)
            begin errors++; $display("FAIL bp_count: got=%0d pending=%0d, required 1000 0", got, q24.size()); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        ready_i = 1'b1;
        for (int i = 0; i <= L; i++) begin
            valid_i = 1'b1;
            randomize_in();
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1)
            begin errors++; $display("FAIL midflight_pre: valid_o=%b, required 1", valid_o); end
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || product_o !== 48'h0 || tag_o !== 4'h0)
            begin errors++; $display("FAIL midflight_async: valid_o=%b product_o=%h tag_o=%h, required 0", valid_o, product_o, tag_o); end
        @(posedge clk);
        @(posedge clk);
        #2 rstn_i = 1'b1;
        for (int i = 0; i < 3 * L; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0 || ready_o !== 1'b1)
            begin errors++; $display("FAIL midflight_stale: stale results=%0d ready_o=%b, required 0 1", stale, ready_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_odd_width();
        int sent = 0, got = 0, cyc = 0, first = -1;
        logic [17:0] e;
        q7.delete();
        r7 = 1'b1;
        while (got < N7 && cyc < 40000) begin
            v7 = sent < N7;
            s7 = sent[14];
            a7 = sent[13:7];
            b7 = sent[6:0];
            t7 = sent[3:0];
            @(negedge clk);
            if (v7 && rd7) begin q7.push_back({t7, model7(s7, a7, b7)}); sent++; end
            if (vo7 && r7) begin
                if (first < 0) first = cyc;
                checks++;
                if (q7.size() == 0) begin errors++; $display("FAIL w7_extra: unexpected result %h", p7); end
                else begin
                    e = q7.pop_front();
                    if ({to7, p7} !== e)
                        begin errors++; $display("FAIL w7_value: tag/product=%h, required %h", {to7, p7}, e); end
                end
                got++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        v7 = 1'b0;
        checks++;
        if (got != N7 || first != L7)
            begin errors++; $display("FAIL w7_latency: got=%0d first=%0d, required %0d %0d", got, first, N7, L7); end
    endtask

    initial begin
        rstn_i   = 1'b0;
        valid_i  = 1'b0;
        signed_i = 1'b0;
        tag_i    = '0;
        a        = '0;
        b        = '0;
        ready_i  = 1'b1;
        v7       = 1'b0;
        s7       = 1'b0;
        t7       = '0;
        a7       = '0;
        b7       = '0;
        r7       = 1'b1;
        test_reset();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_odd_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
